// File: rtl/uart_axilite_fifo.sv
// AXI-Lite UART peripheral: buffered TX FIFO, optional RX FIFO, status/control registers.
// Define UART_RX_EN to build the RX synchronizer, RX engine and RX FIFO; otherwise rx is ignored.
module uart_axilite_fifo #(
   parameter int CLK_FREQ   = 12000000,
   parameter int BAUD       = 9600,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  awaddr,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] wdata,
   input  logic        wvalid,
   output logic        wready,
   output logic        bvalid,
   input  logic        bready,
   output logic [1:0]  bresp,
   input  logic [3:0]  araddr,
   input  logic        arvalid,
   output logic        arready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rvalid,
   input  logic        rready,
   output logic        tx,
   input  logic        rx
);

   localparam int BIT_PERIOD = CLK_FREQ / BAUD;
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
   localparam logic [15:0]   BIT_LAST  = 16'(BIT_PERIOD - 1);
   localparam logic [15:0]   HALF_LAST = 16'(BIT_PERIOD / 2 - 1);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] A_TXDATA = 2'd0;
   localparam logic [1:0] A_RXDATA = 2'd1;
   localparam logic [1:0] A_STATUS = 2'd2;
   localparam logic [1:0] A_CTRL   = 2'd3;

   typedef enum logic {W_IDLE, W_RESP} wState_t;
   typedef enum logic {R_IDLE, R_DATA} rState_t;
   typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_SHIFT} txState_t;

   wState_t       r_wState;
   rState_t       r_rState;
   txState_t      r_txState;
   logic          r_bvalid;
   logic [1:0]    r_bresp;
   logic          r_rvalid;
   logic [1:0]    r_rresp;
   logic [31:0]   r_rdata;
   logic          r_tx;
   logic [9:0]    r_txShift;
   logic [3:0]    r_txBitIdx;
   logic [15:0]   r_txCnt;
   logic [7:0]    r_txMem [FIFO_DEPTH];
   logic [AW-1:0] r_txWr;
   logic [AW-1:0] r_txRd;
   logic [CW-1:0] r_txCount;

   logic          w_wAccept;
   logic          w_rAccept;
   logic          w_txWrite;
   logic          w_ctrlWrite;
   logic          w_flush;
   logic          w_clear;
   logic          w_txFull;
   logic          w_txEmpty;
   logic          w_txPush;
   logic          w_txPop;
   logic          w_txBusy;
   logic [7:0]    w_txHead;
   logic          w_rxEmpty;
   logic          w_rxFull;
   logic          w_overrun;
   logic          w_frameErr;
   logic [7:0]    w_rxHead;
   logic [6:0]    w_status;
   logic [31:0]   w_rdNext;
   logic [1:0]    w_rrNext;
   logic [27:0]   w_unusedBits;

   assign awready   = (r_wState == W_IDLE);
   assign wready    = (r_wState == W_IDLE);
   assign arready   = (r_rState == R_IDLE);
   assign bvalid    = r_bvalid;
   assign bresp     = r_bresp;
   assign rvalid    = r_rvalid;
   assign rresp     = r_rresp;
   assign rdata     = r_rdata;
   assign tx        = r_tx;

   assign w_wAccept   = (r_wState == W_IDLE) && awvalid && wvalid;
   assign w_rAccept   = (r_rState == R_IDLE) && arvalid;
   assign w_txWrite   = w_wAccept && (awaddr[3:2] == A_TXDATA);
   assign w_ctrlWrite = w_wAccept && (awaddr[3:2] == A_CTRL);
   assign w_flush     = w_ctrlWrite && wdata[1];
   assign w_clear     = w_ctrlWrite && wdata[0];
   assign w_txFull    = (r_txCount == DEPTH_C);
   assign w_txEmpty   = (r_txCount == '0);
   assign w_txPush    = w_txWrite && !w_txFull && !w_flush;
   assign w_txHead    = r_txMem[r_txRd];
   assign w_txBusy    = (r_txState != TX_IDLE);
   assign w_unusedBits = {wdata[31:8], awaddr[1:0], araddr[1:0]};

   // The engine pops either from idle or exactly at the end of a stop bit, which keeps frames gapless.
   assign w_txPop = !w_flush && !w_txEmpty &&
                    ((r_txState == TX_IDLE) ||
                     ((r_txState == TX_SHIFT) && (r_txCnt == BIT_LAST) && (r_txBitIdx == 4'd9)));

   assign w_status = {w_frameErr, w_txBusy, w_overrun, w_rxFull, w_rxEmpty, w_txEmpty, w_txFull};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wState <= W_IDLE;
         r_bvalid <= 1'b0;
         r_bresp  <= RESP_OKAY;
      end else begin
         case (r_wState)
            W_IDLE: begin
               if (w_wAccept) begin
                  r_wState <= W_RESP;
                  r_bvalid <= 1'b1;
                  r_bresp  <= (w_txWrite && w_txFull) ? RESP_SLVERR : RESP_OKAY;
               end
            end
            W_RESP: begin
               if (bready) begin
                  r_wState <= W_IDLE;
                  r_bvalid <= 1'b0;
               end
            end
            default: r_wState <= W_IDLE;
         endcase
      end
   end

   always_comb begin
      w_rdNext = 32'd0;
      w_rrNext = RESP_OKAY;
      case (araddr[3:2])
         A_RXDATA: begin
            if (w_rxEmpty) w_rrNext = RESP_SLVERR;
            else           w_rdNext = {24'd0, w_rxHead};
         end
         A_STATUS: w_rdNext = {25'd0, w_status};
         default:  w_rdNext = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rState <= R_IDLE;
         r_rvalid <= 1'b0;
         r_rresp  <= RESP_OKAY;
         r_rdata  <= 32'd0;
      end else begin
         case (r_rState)
            R_IDLE: begin
               if (w_rAccept) begin
                  r_rState <= R_DATA;
                  r_rvalid <= 1'b1;
                  r_rdata  <= w_rdNext;
                  r_rresp  <= w_rrNext;
               end
            end
            R_DATA: begin
               if (rready) begin
                  r_rState <= R_IDLE;
                  r_rvalid <= 1'b0;
               end
            end
            default: r_rState <= R_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_txPush) r_txMem[r_txWr] <= wdata[7:0];
   end

   // Full is judged on the pre-pop count, so a push to a full FIFO is refused even during a pop.
   always_ff @(posedge clk) begin
      if (rst || w_flush) begin
         r_txWr    <= '0;
         r_txRd    <= '0;
         r_txCount <= '0;
      end else begin
         if (w_txPush) r_txWr <= r_txWr + 1'b1;
         if (w_txPop)  r_txRd <= r_txRd + 1'b1;
         r_txCount <= r_txCount + CW'(w_txPush) - CW'(w_txPop);
      end
   end

   // Shift register holds {stop, data, start}; bit 0 is always the bit currently on the line.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_txState  <= TX_IDLE;
         r_tx       <= 1'b1;
         r_txShift  <= '1;
         r_txBitIdx <= 4'd0;
         r_txCnt    <= 16'd0;
      end else begin
         case (r_txState)
            TX_IDLE: begin
               r_tx <= 1'b1;
               if (w_txPop) begin
                  r_txShift <= {1'b1, w_txHead, 1'b0};
                  r_txState <= TX_LOAD;
               end
            end
            TX_LOAD: begin
               r_tx       <= r_txShift[0];
               r_txCnt    <= 16'd0;
               r_txBitIdx <= 4'd0;
               r_txState  <= TX_SHIFT;
            end
            TX_SHIFT: begin
               if (r_txCnt == BIT_LAST) begin
                  r_txCnt <= 16'd0;
                  if (r_txBitIdx == 4'd9) begin
                     if (w_txPop) begin
                        r_txShift  <= {1'b1, w_txHead, 1'b0};
                        r_tx       <= 1'b0;
                        r_txBitIdx <= 4'd0;
                     end else begin
                        r_tx      <= 1'b1;
                        r_txState <= TX_IDLE;
                     end
                  end else begin
                     r_txShift  <= {1'b1, r_txShift[9:1]};
                     r_tx       <= r_txShift[1];
                     r_txBitIdx <= r_txBitIdx + 4'd1;
                  end
               end else begin
                  r_txCnt <= r_txCnt + 16'd1;
               end
            end
            default: begin
               r_txState <= TX_IDLE;
               r_tx      <= 1'b1;
            end
         endcase
      end
   end

`ifdef UART_RX_EN
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;

   rxState_t      r_rxState;
   logic          r_rxSync1;
   logic          r_rxSync2;
   logic          r_rxPrev;
   logic [7:0]    r_rxShift;
   logic [2:0]    r_rxBitIdx;
   logic [15:0]   r_rxCnt;
   logic [7:0]    r_rxMem [FIFO_DEPTH];
   logic [AW-1:0] r_rxWr;
   logic [AW-1:0] r_rxRd;
   logic [CW-1:0] r_rxCount;
   logic          r_overrun;
   logic          r_frameErr;
   logic          w_rxDone;
   logic          w_rxPush;
   logic          w_rxPop;
   logic          w_ovSet;
   logic          w_feSet;

   assign w_rxEmpty  = (r_rxCount == '0);
   assign w_rxFull   = (r_rxCount == DEPTH_C);
   assign w_rxHead   = r_rxMem[r_rxRd];
   assign w_overrun  = r_overrun;
   assign w_frameErr = r_frameErr;
   assign w_rxDone   = (r_rxState == RX_STOP) && (r_rxCnt == BIT_LAST);
   assign w_rxPush   = w_rxDone && r_rxSync2 && !w_rxFull && !w_flush;
   assign w_rxPop    = w_rAccept && (araddr[3:2] == A_RXDATA) && !w_rxEmpty;
   assign w_ovSet    = w_rxDone && r_rxSync2 && w_rxFull;
   assign w_feSet    = w_rxDone && !r_rxSync2;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rxSync1 <= 1'b1;
         r_rxSync2 <= 1'b1;
         r_rxPrev  <= 1'b1;
      end else begin
         r_rxSync1 <= rx;
         r_rxSync2 <= r_rxSync1;
         r_rxPrev  <= r_rxSync2;
      end
   end

   // Start is re-checked half a bit in; after that every bit is sampled one full period later.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rxState  <= RX_IDLE;
         r_rxShift  <= 8'd0;
         r_rxBitIdx <= 3'd0;
         r_rxCnt    <= 16'd0;
      end else begin
         case (r_rxState)
            RX_IDLE: begin
               r_rxCnt <= 16'd0;
               if (!r_rxSync2 && r_rxPrev) r_rxState <= RX_START;
            end
            RX_START: begin
               if (r_rxCnt == HALF_LAST) begin
                  r_rxCnt    <= 16'd0;
                  r_rxBitIdx <= 3'd0;
                  r_rxState  <= r_rxSync2 ? RX_IDLE : RX_DATA;
               end else begin
                  r_rxCnt <= r_rxCnt + 16'd1;
               end
            end
            RX_DATA: begin
               if (r_rxCnt == BIT_LAST) begin
                  r_rxCnt   <= 16'd0;
                  r_rxShift <= {r_rxSync2, r_rxShift[7:1]};
                  if (r_rxBitIdx == 3'd7) r_rxState <= RX_STOP;
                  else                    r_rxBitIdx <= r_rxBitIdx + 3'd1;
               end else begin
                  r_rxCnt <= r_rxCnt + 16'd1;
               end
            end
            RX_STOP: begin
               if (r_rxCnt == BIT_LAST) begin
                  r_rxCnt   <= 16'd0;
                  r_rxState <= RX_IDLE;
               end else begin
                  r_rxCnt <= r_rxCnt + 16'd1;
               end
            end
            default: r_rxState <= RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_rxPush) r_rxMem[r_rxWr] <= r_rxShift;
   end

   always_ff @(posedge clk) begin
      if (rst || w_flush) begin
         r_rxWr    <= '0;
         r_rxRd    <= '0;
         r_rxCount <= '0;
      end else begin
         if (w_rxPush) r_rxWr <= r_rxWr + 1'b1;
         if (w_rxPop)  r_rxRd <= r_rxRd + 1'b1;
         r_rxCount <= r_rxCount + CW'(w_rxPush) - CW'(w_rxPop);
      end
   end

   // A flag being set wins over a clear issued in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overrun  <= 1'b0;
         r_frameErr <= 1'b0;
      end else begin
         if (w_ovSet)      r_overrun <= 1'b1;
         else if (w_clear) r_overrun <= 1'b0;
         if (w_feSet)      r_frameErr <= 1'b1;
         else if (w_clear) r_frameErr <= 1'b0;
      end
   end
`else
   logic [1:0] w_unusedRx;

   assign w_rxEmpty  = 1'b1;
   assign w_rxFull   = 1'b0;
   assign w_overrun  = 1'b0;
   assign w_frameErr = 1'b0;
   assign w_rxHead   = 8'd0;
   assign w_unusedRx = {rx, w_clear};
`endif

endmodule
